// File: rtl/alt_vipvfr121_vfr_bank_scheduler.sv
// ---------------------------------------------------------------------------
// alt_vipvfr121_vfr_bank_scheduler
//
// Double-buffer bank scheduler for the frame reader. Software writes a frame
// into one of two banks and pulses commit; this block hands the committed bank
// to the frame reader controller at the next frame boundary, repeats the last
// frame when nothing new has been committed, counts completed frames and
// raises sticky interrupt / collision flags.
//
// Ports:
//   clock          in   sole clock, rising edge
//   reset          in   synchronous, active-low
//   enable         in   software run enable (level)
//   commit         in   one-cycle pulse: bank commit_bank is ready
//   commit_bank    in   bank index qualified by commit
//   irq_clear      in   one-cycle pulse clearing irq and collision
//   running        in   controller busy flag
//   frame_complete in   controller end-of-frame pulse
//   go_bit         out  start request to controller
//   next_bank      out  bank the controller reads on its next start
//   frames_shown   out  completed-frame counter (wraps)
//   irq            out  sticky: a frame from a newly committed bank finished
//   collision      out  sticky: a commit targeted the bank being scanned
// ---------------------------------------------------------------------------
module alt_vipvfr121_vfr_bank_scheduler #(
    parameter int unsigned FRAME_COUNT_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         commit,
    input  logic                         commit_bank,
    input  logic                         irq_clear,
    input  logic                         running,
    input  logic                         frame_complete,
    output logic                         go_bit,
    output logic                         next_bank,
    output logic [FRAME_COUNT_WIDTH-1:0] frames_shown,
    output logic                         irq,
    output logic                         collision
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    localparam logic [FRAME_COUNT_WIDTH-1:0] COUNT_ONE = FRAME_COUNT_WIDTH'(1);

    state_t state;
    logic   have_frame;  // at least one bank has ever been committed
    logic   pend_valid;  // a commit is waiting for the next frame boundary
    logic   pend_bank;
    logic   swap;        // the frame in flight came from a fresh commit

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            go_bit       <= 1'b0;
            next_bank    <= 1'b0;
            frames_shown <= '0;
            irq          <= 1'b0;
            collision    <= 1'b0;
            have_frame   <= 1'b0;
            pend_valid   <= 1'b0;
            pend_bank    <= 1'b0;
            swap         <= 1'b0;
        end else begin
            // Clear is written first so any set later in this block wins.
            if (irq_clear) begin
                irq       <= 1'b0;
                collision <= 1'b0;
            end

            if (commit) begin
                pend_valid <= 1'b1;
                pend_bank  <= commit_bank;
                have_frame <= 1'b1;
                if ((state == WAIT_START || state == WAIT_DONE) &&
                    commit_bank == next_bank)
                    collision <= 1'b1;
            end

            case (state)
                IDLE: begin
                    go_bit <= 1'b0;
                    // A commit in this same cycle already counts as a frame.
                    if (enable && (have_frame || commit))
                        state <= ISSUE;
                end

                ISSUE: begin
                    if (pend_valid) begin
                        // next_bank takes the pre-commit pending bank; a
                        // commit in this cycle stays pending for next time.
                        next_bank <= pend_bank;
                        swap      <= 1'b1;
                        if (!commit)
                            pend_valid <= 1'b0;
                    end else begin
                        swap <= 1'b0;
                    end
                    go_bit <= 1'b1;
                    state  <= WAIT_START;
                end

                WAIT_START: begin
                    if (running) begin
                        go_bit <= 1'b0;
                        state  <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    go_bit <= 1'b0;
                    if (frame_complete) begin
                        frames_shown <= frames_shown + COUNT_ONE;
                        if (swap)
                            irq <= 1'b1;
                        state <= enable ? ISSUE : IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alt_vipvfr121_vfr_bank_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for alt_vipvfr121_vfr_bank_scheduler.
// A second, narrow-counter instance shares all inputs with the main one so
// counter wrap-around can be reached in a handful of frames.
// Expected banks are queued when a commit is driven and popped when the DUT
// raises go_bit.
// ---------------------------------------------------------------------------
module tb_alt_vipvfr121_vfr_bank_scheduler;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        commit;
    logic        commit_bank;
    logic        irq_clear;
    logic        running;
    logic        frame_complete;
    logic        go_bit;
    logic        next_bank;
    logic [15:0] frames_shown;
    logic        irq;
    logic        collision;

    logic        s_go_bit;
    logic        s_next_bank;
    logic [3:0]  s_frames_shown;
    logic        s_irq;
    logic        s_collision;

    int total;
    int bad;
    logic exp_q[$];
    logic exp_bank;
    logic go_seen;

    alt_vipvfr121_vfr_bank_scheduler #(.FRAME_COUNT_WIDTH(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .commit         (commit),
        .commit_bank    (commit_bank),
        .irq_clear      (irq_clear),
        .running        (running),
        .frame_complete (frame_complete),
        .go_bit         (go_bit),
        .next_bank      (next_bank),
        .frames_shown   (frames_shown),
        .irq            (irq),
        .collision      (collision)
    );

    alt_vipvfr121_vfr_bank_scheduler #(.FRAME_COUNT_WIDTH(4)) dut_small (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .commit         (commit),
        .commit_bank    (commit_bank),
        .irq_clear      (irq_clear),
        .running        (running),
        .frame_complete (frame_complete),
        .go_bit         (s_go_bit),
        .next_bank      (s_next_bank),
        .frames_shown   (s_frames_shown),
        .irq            (s_irq),
        .collision      (s_collision)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        enable         = 1'b0;
        commit         = 1'b0;
        commit_bank    = 1'b0;
        irq_clear      = 1'b0;
        running        = 1'b0;
        frame_complete = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic pulse_commit(input logic b);
        commit      = 1'b1;
        commit_bank = b;
        tick();
        commit = 1'b0;
    endtask

    // Bounded wait for go_bit; callers compare go_bit afterwards.
    task automatic wait_go();
        for (int i = 0; i < 20; i++) begin
            if (go_bit === 1'b1) break;
            tick();
        end
    endtask

    // Called in WAIT_START: acknowledge start, then end the frame.
    task automatic finish_frame();
        running = 1'b1;
        tick();
        running = 1'b0;
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
    endtask

    function automatic logic pop_exp();
        if (exp_q.size() == 0) return 1'bx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        do_reset();
        total++;
        if ({go_bit, next_bank, irq, collision, frames_shown} !== 20'h0) begin
            bad++;
            $display("FAIL reset_state: got go=%b bank=%b irq=%b col=%b frames=%h want all 0",
                     go_bit, next_bank, irq, collision, frames_shown);
        end
    endtask

    task automatic test_no_commit();
        do_reset();
        enable  = 1'b1;
        go_seen = 1'b0;
        repeat (20) begin
            tick();
            if (go_bit !== 1'b0) go_seen = 1'b1;
        end
        total++;
        if (go_seen !== 1'b0) begin
            bad++;
            $display("FAIL no_commit_go: got go seen=%b want 0", go_seen);
        end
        total++;
        if (frames_shown !== 16'h0) begin
            bad++;
            $display("FAIL no_commit_frames: got %h want 0000", frames_shown);
        end
        enable = 1'b0;
    endtask

    task automatic test_swap_and_repeat();
        do_reset();
        enable      = 1'b1;
        commit      = 1'b1;
        commit_bank = 1'b1;
        exp_q.push_back(1'b1);
        tick();
        commit = 1'b0;
        total++;
        if (go_bit !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: got go=%b want 0", go_bit);
        end
        tick();
        total++;
        if (go_bit !== 1'b1) begin
            bad++;
            $display("FAIL latency_go: got go=%b want 1", go_bit);
        end
        exp_bank = pop_exp();
        total++;
        if (next_bank !== exp_bank) begin
            bad++;
            $display("FAIL swap_bank: got %b want %b", next_bank, exp_bank);
        end
        repeat (3) begin
            tick();
            total++;
            if (go_bit !== 1'b1) begin
                bad++;
                $display("FAIL go_hold: got go=%b want 1", go_bit);
            end
        end
        running = 1'b1;
        tick();
        running = 1'b0;
        total++;
        if (go_bit !== 1'b0) begin
            bad++;
            $display("FAIL go_drop: got go=%b want 0", go_bit);
        end
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
        total++;
        if ({frames_shown, irq} !== {16'd1, 1'b1}) begin
            bad++;
            $display("FAIL first_done: got frames=%0d irq=%b want 1 1", frames_shown, irq);
        end
        exp_q.push_back(1'b1);
        tick();
        exp_bank = pop_exp();
        total++;
        if ({go_bit, next_bank} !== {1'b1, exp_bank}) begin
            bad++;
            $display("FAIL repeat_issue: got go=%b bank=%b want 1 %b", go_bit, next_bank, exp_bank);
        end
        finish_frame();
        total++;
        if ({frames_shown, irq} !== {16'd2, 1'b1}) begin
            bad++;
            $display("FAIL repeat_done: got frames=%0d irq=%b want 2 1", frames_shown, irq);
        end
        enable = 1'b0;
    endtask

    task automatic test_collision_irq_clear();
        do_reset();
        enable = 1'b1;
        exp_q.push_back(1'b1);
        pulse_commit(1'b1);
        wait_go();
        exp_bank = pop_exp();
        total++;
        if ({go_bit, next_bank, collision} !== {1'b1, exp_bank, 1'b0}) begin
            bad++;
            $display("FAIL col_start: got go=%b bank=%b col=%b want 1 %b 0",
                     go_bit, next_bank, collision, exp_bank);
        end
        exp_q.push_back(1'b1);
        pulse_commit(1'b1);
        total++;
        if (collision !== 1'b1) begin
            bad++;
            $display("FAIL col_set: got %b want 1", collision);
        end
        finish_frame();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL col_irq: got %b want 1", irq);
        end
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        total++;
        if ({irq, collision} !== 2'b00) begin
            bad++;
            $display("FAIL irq_clear: got irq=%b col=%b want 0 0", irq, collision);
        end
        exp_bank = pop_exp();
        total++;
        if ({go_bit, next_bank} !== {1'b1, exp_bank}) begin
            bad++;
            $display("FAIL col_reissue: got go=%b bank=%b want 1 %b", go_bit, next_bank, exp_bank);
        end
        running = 1'b1;
        tick();
        running        = 1'b0;
        frame_complete = 1'b1;
        irq_clear      = 1'b1;
        tick();
        frame_complete = 1'b0;
        irq_clear      = 1'b0;
        total++;
        if ({irq, collision} !== 2'b10) begin
            bad++;
            $display("FAIL set_wins: got irq=%b col=%b want 1 0", irq, collision);
        end
        enable = 1'b0;
    endtask

    task automatic test_pending_override();
        do_reset();
        enable = 1'b1;
        exp_q.push_back(1'b0);
        pulse_commit(1'b0);
        wait_go();
        exp_bank = pop_exp();
        total++;
        if ({go_bit, next_bank} !== {1'b1, exp_bank}) begin
            bad++;
            $display("FAIL pend_first: got go=%b bank=%b want 1 %b", go_bit, next_bank, exp_bank);
        end
        pulse_commit(1'b0);
        exp_q.push_back(1'b1);
        pulse_commit(1'b1);
        finish_frame();
        // This cycle is ISSUE: a commit here stays pending for the frame after.
        exp_q.push_back(1'b0);
        commit      = 1'b1;
        commit_bank = 1'b0;
        tick();
        commit = 1'b0;
        exp_bank = pop_exp();
        total++;
        if ({go_bit, next_bank} !== {1'b1, exp_bank}) begin
            bad++;
            $display("FAIL pend_latest: got go=%b bank=%b want 1 %b", go_bit, next_bank, exp_bank);
        end
        finish_frame();
        tick();
        exp_bank = pop_exp();
        total++;
        if ({go_bit, next_bank} !== {1'b1, exp_bank}) begin
            bad++;
            $display("FAIL pend_issue_commit: got go=%b bank=%b want 1 %b", go_bit, next_bank, exp_bank);
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1;
        pulse_commit(1'b1);
        wait_go();
        running = 1'b1;
        tick();
        running = 1'b0;
        enable  = 1'b0;
        tick();
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
        total++;
        if ({frames_shown, go_bit} !== {16'd1, 1'b0}) begin
            bad++;
            $display("FAIL drop_done: got frames=%0d go=%b want 1 0", frames_shown, go_bit);
        end
        go_seen = 1'b0;
        repeat (5) begin
            tick();
            if (go_bit !== 1'b0) go_seen = 1'b1;
        end
        total++;
        if ({go_seen, frames_shown} !== {1'b0, 16'd1}) begin
            bad++;
            $display("FAIL drop_idle: got go seen=%b frames=%0d want 0 1", go_seen, frames_shown);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        enable = 1'b1;
        pulse_commit(1'b1);
        repeat (15) begin
            wait_go();
            finish_frame();
        end
        total++;
        if ({s_frames_shown, frames_shown} !== {4'hF, 16'd15}) begin
            bad++;
            $display("FAIL wrap_pre: got small=%h big=%0d want f 15", s_frames_shown, frames_shown);
        end
        wait_go();
        finish_frame();
        total++;
        if ({s_frames_shown, frames_shown} !== {4'h0, 16'd16}) begin
            bad++;
            $display("FAIL wrap: got small=%h big=%0d want 0 16", s_frames_shown, frames_shown);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        enable = 1'b1;
        pulse_commit(1'b1);
        wait_go();
        total++;
        if (go_bit !== 1'b1) begin
            bad++;
            $display("FAIL mid_go: got %b want 1", go_bit);
        end
        pulse_commit(1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total++;
        if ({go_bit, next_bank, irq, collision, frames_shown} !== 20'h0) begin
            bad++;
            $display("FAIL mid_reset: got go=%b bank=%b irq=%b col=%b frames=%h want all 0",
                     go_bit, next_bank, irq, collision, frames_shown);
        end
        go_seen = 1'b0;
        repeat (10) begin
            tick();
            if (go_bit !== 1'b0) go_seen = 1'b1;
        end
        total++;
        if (go_seen !== 1'b0) begin
            bad++;
            $display("FAIL pend_discard: got go seen=%b want 0", go_seen);
        end
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
        total++;
        if ({frames_shown, irq} !== {16'd0, 1'b0}) begin
            bad++;
            $display("FAIL spurious_done: got frames=%0d irq=%b want 0 0", frames_shown, irq);
        end
        enable = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b0;
        enable         = 1'b0;
        commit         = 1'b0;
        commit_bank    = 1'b0;
        irq_clear      = 1'b0;
        running        = 1'b0;
        frame_complete = 1'b0;
        tick();
        test_reset();
        test_no_commit();
        test_swap_and_repeat();
        test_collision_irq_clear();
        test_pending_override();
        test_enable_drop();
        test_wrap();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alt_vipvfr121_vfr_bank_scheduler.md
ALT_VIPVFR121_VFR_BANK_SCHEDULER -- requirements
Module: alt_vipvfr121_vfr_bank_scheduler

Interface
REQ-001 SHALL have parameter FRAME_COUNT_WIDTH, default 16, width of frames_shown counter.
REQ-002 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset is synchronous and active-low.
REQ-004 SHALL have port enable  input  1  software run enable; level.
REQ-005 SHALL have port commit  input  1  one-cycle pulse: software finished writing bank commit_bank.
REQ-006 SHALL have port commit_bank  input  1  bank index qualified by commit.
REQ-007 SHALL have port irq_clear  input  1  one-cycle pulse clearing irq and collision.
REQ-008 SHALL have port running  input  1  frame reader controller busy flag.
REQ-009 SHALL have port frame_complete  input  1  controller end-of-frame pulse.
REQ-010 SHALL have port go_bit  output  1  start request to controller.
REQ-011 SHALL have port next_bank  output  1  bank controller reads on next start.
REQ-012 SHALL have port frames_shown  output  FRAME_COUNT_WIDTH  completed-frame counter.
REQ-013 SHALL have port irq  output  1  sticky swap-done interrupt.
REQ-014 SHALL have port collision  output  1  sticky: commit targeted bank under scan.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-016 SHALL hold internal have_frame (set by first commit, never cleared except reset), pend_valid and pend_bank.
REQ-017 On commit in any state: pend_valid<=1, pend_bank<=commit_bank, have_frame<=1; latest commit overrides older pending.
REQ-018 IDLE: go_bit=0; go to ISSUE when enable=1 and have_frame=1 (pending commit in same cycle counts).
REQ-019 ISSUE (one cycle): if pend_valid, next_bank<=pend_bank, swap flag<=1, pend_valid<=0; else next_bank unchanged (repeat frame), swap flag<=0; go_bit<=1; go to WAIT_START.
REQ-020 Commit in the ISSUE cycle SHALL win over the clear: pend_valid stays 1 with new bank; next_bank takes pre-commit pend_bank.
REQ-021 WAIT_START: hold go_bit=1 and next_bank stable until running=1 sampled; then go_bit<=0, go to WAIT_DONE.
REQ-022 WAIT_DONE: go_bit=0; on frame_complete: frames_shown+=1 (wraps all-ones->0), irq<=1 if swap flag, then ISSUE if enable=1 else IDLE.
REQ-023 frame_complete outside WAIT_DONE SHALL be ignored (no count, no irq).
REQ-024 enable deassert in WAIT_START/WAIT_DONE SHALL NOT abort; current frame finishes, then IDLE.
REQ-025 Commit with commit_bank==next_bank while in WAIT_START or WAIT_DONE SHALL set collision<=1; pending update still applies.
REQ-026 irq_clear SHALL clear irq and collision next cycle; set and clear in same cycle -> set wins.
REQ-027 go_bit SHALL never be 1 in IDLE or WAIT_DONE; next_bank SHALL change only in ISSUE.
REQ-028 Latency: enable with have_frame -> go_bit=1 two cycles later (IDLE->ISSUE->output registered).

Reset
REQ-029 When reset=0 at a rising edge: state IDLE, go_bit=0, next_bank=0, frames_shown=0, irq=0, collision=0, have_frame=0, pend_valid=0, pend_bank=0, swap flag=0.
REQ-030 Reset mid-frame SHALL take effect immediately regardless of running/frame_complete; pending commits are discarded.

Verification
REQ-031 enable=1, no commit for 20 cycles -> go_bit stays 0, frames_shown=0.
REQ-032 commit bank1, enable=1; running rises 3 cycles after go_bit -> go_bit held 1 until running seen, next_bank=1; frame_complete -> frames_shown=1, irq=1, go_bit reasserted with next_bank=1 (repeat), second completion leaves irq set, no new swap.
REQ-033 While scanning bank1 commit bank1 -> collision=1; irq_clear pulse -> irq=0, collision=0; irq_clear coincident with swap completion -> irq=1.
REQ-034 commit bank0 then bank1 during one frame -> next ISSUE selects bank1, pend_valid=0; commit bank0 in ISSUE cycle -> next_bank=1, following frame uses bank0.
REQ-035 enable dropped in WAIT_DONE -> frame completes, frames_shown increments, state IDLE, go_bit=0; frames_shown preloaded to 0xFFFF wraps to 0x0000.
REQ-036 reset=0 during WAIT_START with go_bit=1 -> next cycle go_bit=0, all outputs at reset values; spurious frame_complete in IDLE ignored.
